// File: rtl/hazard_scheduler.sv
// Hazard unit for the 5-stage core: EX forwarding, load-use stall, branch flush,
// multi-cycle data-memory wait FSM with sticky timeout and saturating perf counters.
module hazard_scheduler #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic             PCSrcE,
    input  logic             dmem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic            memop, mem_stall, lw_stall, any_stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && RdM == rs && rs != 5'd0)      return 2'b10;
        else if (RegWriteW && RdW == rs && rs != 5'd0) return 2'b01;
        else                                           return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E);
    assign ForwardBE = fwd_sel(Rs2E);

    assign memop     = MemReadM | MemWriteM;
    assign dmem_req  = memop;
    assign mem_stall = memop && !dmem_ready;
    assign lw_stall  = ResultSrcE == 2'b01 && RdE != 5'd0 && (Rs1D == RdE || Rs2D == RdE);

    // A memory stall freezes the whole front end, so a resolved branch in E is
    // held rather than flushed; W gets a bubble while M waits.
    always_comb begin
        StallF = lw_stall;
        StallD = lw_stall;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end
    end

    assign any_stall = StallF | StallD | StallE | StallM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (mem_stall) begin
                    state    <= WAIT;
                    wait_cnt <= WC_W'(1);
                    if (MEM_TIMEOUT <= 1) mem_err <= 1'b1;
                end
                WAIT: if (dmem_ready) begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end else if (wait_cnt != WC_MAX) begin
                    wait_cnt <= wait_cnt + WC_W'(1);
                    if (wait_cnt == WC_LAST) mem_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (any_stall && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (PCSrcE && !mem_stall && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule
